instr_sequencer: RTL and testbench

Multi-cycle fetch/decode/execute sequencer that owns the program counter and instruction register for the 16-bit datapath. It fetches instruction words from shared memory over a req/ack handshake, hands each word to the control unit with a one-cycle issue strobe, waits for the control unit to report completion, then applies any status-qualified branch before fetching the next word. It sits between instruction memory and the control unit and is the only writer of PC and IR.

---
 rtl/instr_sequencer_if.sv | 24 ++
 rtl/instr_sequencer.sv | 119 +++++++++++
 tb/tb_instr_sequencer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/instr_sequencer_if.sv
// Instruction-fetch bus between the sequencer (master) and instruction memory (slave).
// A fetch is a held request on mem_req/mem_addr that completes on the cycle mem_ack is high.
interface instr_sequencer_if #(
  parameter int PC_W = 16
);
  logic            mem_req;
  logic [PC_W-1:0] mem_addr;
  logic            mem_ack;
  logic [15:0]     mem_rdata;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/instr_sequencer.sv
// Fetch/decode/execute sequencer owning PC and IR for the 16-bit datapath.
// Optional retired-instruction counter is built when SEQ_PERF_CNT_EN is defined.
module instr_sequencer #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                go,
  input  logic                halt_req,
  instr_sequencer_if.master   mem,
  output logic [15:0]         ir,
  output logic                ir_valid,
  input  logic                exec_done,
  input  logic                br_valid,
  input  logic [2:0]          br_cond,
  input  logic [PC_W-1:0]     br_target,
  input  logic [3:0]          status,
  output logic [PC_W-1:0]     pc,
  output logic                halted,
  output logic [31:0]         instr_count
);

  typedef enum logic [1:0] {
    S_HALT,
    S_FETCH,
    S_DECODE,
    S_EXEC
  } state_t;

  state_t          r_state;
  state_t          w_stateNext;
  logic [PC_W-1:0] r_pc;
  logic [15:0]     r_ir;
  logic            w_condTrue;
  logic            w_retire;
  logic            w_fetchDone;

  // status is {V,C,N,Z}
  always_comb begin
    w_condTrue = 1'b0;
    case (br_cond)
      3'b000:  w_condTrue = 1'b1;
      3'b001:  w_condTrue = status[0];
      3'b010:  w_condTrue = status[1];
      3'b011:  w_condTrue = status[2];
      3'b100:  w_condTrue = status[3];
      3'b101:  w_condTrue = ~status[0];
      3'b110:  w_condTrue = ~status[1];
      default: w_condTrue = 1'b0;
    endcase
  end

  always_comb begin
    w_stateNext = r_state;
    w_retire    = 1'b0;
    w_fetchDone = 1'b0;
    case (r_state)
      S_HALT: begin
        if (go) w_stateNext = S_FETCH;
      end
      S_FETCH: begin
        if (mem.mem_ack) begin
          w_fetchDone = 1'b1;
          w_stateNext = S_DECODE;
        end
      end
      S_DECODE: begin
        w_stateNext = S_EXEC;
      end
      S_EXEC: begin
        if (exec_done) begin
          w_retire    = 1'b1;
          w_stateNext = halt_req ? S_HALT : S_FETCH;
        end
      end
      default: w_stateNext = S_HALT;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_HALT;
    else        r_state <= w_stateNext;
  end

  // Fetch and branch never coincide, so one priority chain covers all PC writes.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc <= RESET_PC;
      r_ir <= 16'h0000;
    end else if (w_fetchDone) begin
      r_ir <= mem.mem_rdata;
      r_pc <= r_pc + PC_W'(1);
    end else if (w_retire && br_valid && w_condTrue) begin
      r_pc <= br_target;
    end
  end

`ifdef SEQ_PERF_CNT_EN
  logic [31:0] r_instrCount;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)        r_instrCount <= 32'h0;
    else if (w_retire) r_instrCount <= r_instrCount + 32'd1;
  end

  assign instr_count = r_instrCount;
`else
  assign instr_count = 32'h0;
`endif

  assign mem.mem_req  = (r_state == S_FETCH);
  assign mem.mem_addr = r_pc;
  assign ir_valid     = (r_state == S_DECODE);
  assign halted       = (r_state == S_HALT);
  assign ir           = r_ir;
  assign pc           = r_pc;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: sequential fetch, wait states, branches, halt/resume,
// PC wrap from RESET_PC=FFFF and asynchronous reset mid-fetch.
module tb_instr_sequencer;

  logic        clock;
  logic        reset0;
  logic        reset1;
  logic        go;
  logic        halt_req;
  logic        exec_done;
  logic        br_valid;
  logic [2:0]  br_cond;
  logic [15:0] br_target;
  logic [3:0]  status;

  logic [15:0] ir0, ir1;
  logic        irValid0, irValid1;
  logic [15:0] pc0, pc1;
  logic        halted0, halted1;
  logic [31:0] count0, count1;

  int errors;
  int checks;
  logic [31:0] expCount;

  instr_sequencer_if #(.PC_W(16)) if0 ();
  instr_sequencer_if #(.PC_W(16)) if1 ();

  instr_sequencer #(.PC_W(16), .RESET_PC(16'h0000)) dut0 (
    .clock(clock), .reset(reset0), .go(go), .halt_req(halt_req), .mem(if0.master),
    .ir(ir0), .ir_valid(irValid0), .exec_done(exec_done), .br_valid(br_valid),
    .br_cond(br_cond), .br_target(br_target), .status(status), .pc(pc0),
    .halted(halted0), .instr_count(count0)
  );

  instr_sequencer #(.PC_W(16), .RESET_PC(16'hFFFF)) dut1 (
    .clock(clock), .reset(reset1), .go(go), .halt_req(halt_req), .mem(if1.master),
    .ir(ir1), .ir_valid(irValid1), .exec_done(exec_done), .br_valid(br_valid),
    .br_cond(br_cond), .br_target(br_target), .status(status), .pc(pc1),
    .halted(halted1), .instr_count(count1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Advance n cycles; inputs are driven and outputs sampled on the falling edge.
  task automatic applyStimulus(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
`ifdef SEQ_PERF_CNT_EN
    expCount = 32'd10;
`else
    expCount = 32'd0;
`endif
    reset0 = 1'b0; reset1 = 1'b0;
    go = 1'b0; halt_req = 1'b0; exec_done = 1'b0;
    br_valid = 1'b0; br_cond = 3'b000; br_target = 16'h0000; status = 4'b0000;
    if0.mem_ack = 1'b0; if0.mem_rdata = 16'h0000;
    if1.mem_ack = 1'b0; if1.mem_rdata = 16'h0000;

    applyStimulus(2);
    checkOutput("rst_halted", {31'b0, halted0}, 32'd1);
    checkOutput("rst_mem_req", {31'b0, if0.mem_req}, 32'd0);
    checkOutput("rst_pc", {16'b0, pc0}, 32'h0000);
    checkOutput("rst_ir", {16'b0, ir0}, 32'h0000);
    checkOutput("rst_ir_valid", {31'b0, irValid0}, 32'd0);
    checkOutput("rst_count", count0, 32'd0);
    checkOutput("rst1_pc", {16'b0, pc1}, 32'hFFFF);

    // Sequential fetch with ack and exec_done tied high
    reset0 = 1'b1;
    applyStimulus(1);
    if0.mem_ack = 1'b1; if0.mem_rdata = 16'h1111; exec_done = 1'b1; go = 1'b1;
    applyStimulus(1);
    go = 1'b0;
    for (int k = 0; k < 3; k++) begin
      checkOutput($sformatf("seq%0d_mem_req", k), {31'b0, if0.mem_req}, 32'd1);
      checkOutput($sformatf("seq%0d_mem_addr", k), {16'b0, if0.mem_addr}, k);
      applyStimulus(1);
      checkOutput($sformatf("seq%0d_ir_valid", k), {31'b0, irValid0}, 32'd1);
      checkOutput($sformatf("seq%0d_ir", k), {16'b0, ir0}, 32'h1111);
      applyStimulus(1);
      checkOutput($sformatf("seq%0d_exec_strobe", k), {31'b0, irValid0}, 32'd0);
      applyStimulus(1);
    end
    checkOutput("seq_pc_after3", {16'b0, pc0}, 32'h0003);

    // Wait states: ack arrives in the fifth FETCH cycle
    if0.mem_ack = 1'b0; if0.mem_rdata = 16'h5D1A;
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1);
      checkOutput($sformatf("ws_req%0d", k), {31'b0, if0.mem_req}, 32'd1);
    end
    checkOutput("ws_pc_hold", {16'b0, pc0}, 32'h0003);
    if0.mem_ack = 1'b1;
    applyStimulus(1);
    checkOutput("ws_ir", {16'b0, ir0}, 32'h5D1A);
    checkOutput("ws_ir_valid", {31'b0, irValid0}, 32'd1);
    checkOutput("ws_req_drop", {31'b0, if0.mem_req}, 32'd0);
    checkOutput("ws_pc_inc", {16'b0, pc0}, 32'h0004);
    exec_done = 1'b0;
    applyStimulus(1);
    checkOutput("ws_ir_valid_1cyc", {31'b0, irValid0}, 32'd0);

    // Branch inputs must be ignored while exec_done is low
    br_valid = 1'b1; br_cond = 3'b000; br_target = 16'h0BAD;
    applyStimulus(1);
    checkOutput("br_ignored", {16'b0, pc0}, 32'h0004);

    // Taken branch on N
    status = 4'b0010; br_cond = 3'b010; br_target = 16'h0040; exec_done = 1'b1;
    applyStimulus(1);
    checkOutput("brN_mem_addr", {16'b0, if0.mem_addr}, 32'h0040);
    checkOutput("brN_mem_req", {31'b0, if0.mem_req}, 32'd1);
    exec_done = 1'b0; br_valid = 1'b0;
    applyStimulus(2);

    // Not-taken branch on Z (Z=0)
    br_valid = 1'b1; br_cond = 3'b001; br_target = 16'h0080; exec_done = 1'b1;
    applyStimulus(1);
    checkOutput("brZ_mem_addr", {16'b0, if0.mem_addr}, 32'h0041);

    // Halt requested mid-fetch: fetch finishes, instruction issues and retires
    br_valid = 1'b0; exec_done = 1'b0; halt_req = 1'b1;
    if0.mem_ack = 1'b0; if0.mem_rdata = 16'hA5C3;
    applyStimulus(1);
    checkOutput("halt_fetch_held", {31'b0, if0.mem_req}, 32'd1);
    if0.mem_ack = 1'b1;
    applyStimulus(1);
    checkOutput("halt_issue", {31'b0, irValid0}, 32'd1);
    applyStimulus(1);
    checkOutput("halt_not_yet", {31'b0, halted0}, 32'd0);
    exec_done = 1'b1;
    applyStimulus(1);
    checkOutput("halt_halted", {31'b0, halted0}, 32'd1);
    checkOutput("halt_mem_req", {31'b0, if0.mem_req}, 32'd0);
    checkOutput("halt_pc", {16'b0, pc0}, 32'h0042);
    halt_req = 1'b0;
    applyStimulus(3);
    checkOutput("halt_stays", {31'b0, halted0}, 32'd1);
    checkOutput("halt_ir_hold", {16'b0, ir0}, 32'hA5C3);

    // Resume at saved pc, retire four more, then halt
    if0.mem_rdata = 16'h2222; go = 1'b1;
    applyStimulus(1);
    go = 1'b0;
    checkOutput("resume_addr", {16'b0, if0.mem_addr}, 32'h0042);
    applyStimulus(11);
    halt_req = 1'b1;
    applyStimulus(1);
    halt_req = 1'b0;
    checkOutput("final_halted", {31'b0, halted0}, 32'd1);
    checkOutput("final_pc", {16'b0, pc0}, 32'h0046);
    checkOutput("final_count", count0, expCount);

    // RESET_PC=FFFF wraps to 0000; dut0 parks in FETCH without ack
    if0.mem_ack = 1'b0;
    reset1 = 1'b1;
    if1.mem_ack = 1'b1; if1.mem_rdata = 16'h3333;
    applyStimulus(1);
    go = 1'b1;
    applyStimulus(1);
    go = 1'b0;
    checkOutput("wrap_addr0", {16'b0, if1.mem_addr}, 32'hFFFF);
    applyStimulus(1);
    checkOutput("wrap_pc", {16'b0, pc1}, 32'h0000);
    applyStimulus(2);
    checkOutput("wrap_addr1", {16'b0, if1.mem_addr}, 32'h0000);
    if1.mem_ack = 1'b0;
    applyStimulus(1);
    checkOutput("ar_req_before", {31'b0, if1.mem_req}, 32'd1);

    // Asynchronous reset between clock edges
    #2;
    reset1 = 1'b0; reset0 = 1'b0;
    #1;
    checkOutput("ar_mem_req", {31'b0, if1.mem_req}, 32'd0);
    checkOutput("ar_pc", {16'b0, pc1}, 32'hFFFF);
    checkOutput("ar_halted", {31'b0, halted1}, 32'd1);
    checkOutput("ar_ir", {16'b0, ir1}, 32'h0000);
    checkOutput("ar_count1", count1, 32'd0);
    checkOutput("ar_dut0_req", {31'b0, if0.mem_req}, 32'd0);
    checkOutput("ar_dut0_count", count0, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
